// File: rtl/spi_reg_ctrl.sv
// Register-file controller behind a byte-level SPI slave: command byte, then burst write or read.
// Build option: define AUTOINC_EN so the address advances per data byte / tx_load; otherwise the address stays fixed for the frame.
module spi_reg_ctrl #(
  parameter int         NREGS   = 8,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_load,
  output logic [7:0]         tx_data,
  output logic [8*NREGS-1:0] regs_flat,
  output logic               wr_stb,
  output logic [6:0]         wr_addr,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t                 state, state_nxt;
  logic [6:0]             addr, addr_inc, addr_nxt;
  logic [NREGS-1:0][7:0]  regs;
  logic [7:0]             tx_nxt;
  logic                   wr_en;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < 8'(NREGS);
  endfunction

  // Unimplemented addresses read back as 0xFF.
  function automatic logic [7:0] rd(input logic [NREGS-1:0][7:0] r, input logic [6:0] a);
    logic [7:0] v;
    v = 8'hFF;
    for (int i = 0; i < NREGS; i++)
      if (a == 7'(i)) v = r[i];
    return v;
  endfunction

`ifdef AUTOINC_EN
  assign addr_inc = addr + 7'd1;
`else
  assign addr_inc = addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // frame_start outranks frame_end so a glitched SSEL always restarts cleanly.
  always_comb begin
    state_nxt = state;
    case (state)
      CMD:     if (rx_valid) state_nxt = rx_data[7] ? RD : WR;
      default: ;
    endcase
    if (frame_end)   state_nxt = IDLE;
    if (frame_start) state_nxt = CMD;
  end

  // A byte arriving with frame_end is still processed; one arriving with frame_start is abandoned.
  always_comb begin
    addr_nxt = addr;
    tx_nxt   = tx_data;
    wr_en    = 1'b0;
    case (state)
      CMD: begin
        if (tx_load) tx_nxt = 8'h00;
        if (rx_valid) begin
          addr_nxt = rx_data[6:0];
          if (rx_data[7]) tx_nxt = rd(regs, rx_data[6:0]);
        end
      end
      WR: if (rx_valid) begin
        wr_en    = in_range(addr);
        addr_nxt = addr_inc;
      end
      RD: if (tx_load) begin
        addr_nxt = addr_inc;
        tx_nxt   = rd(regs, addr_inc);
      end
      default: ;
    endcase
    if (frame_end) tx_nxt = 8'h00;
    if (frame_start) begin
      addr_nxt = addr;
      tx_nxt   = 8'h00;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      regs    <= {NREGS{RST_VAL}};
      tx_data <= 8'h00;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
    end else begin
      addr    <= addr_nxt;
      tx_data <= tx_nxt;
      wr_stb  <= wr_en;
      if (wr_en) wr_addr <= addr;
      for (int i = 0; i < NREGS; i++)
        if (wr_en && addr == 7'(i)) regs[i] <= rx_data;
      if (frame_start)    busy <= 1'b1;
      else if (frame_end) busy <= 1'b0;
    end
  end

  assign regs_flat = regs;

endmodule
